// File: rtl/mc_control_unit_pkg.sv
// rtl/mc_control_unit_pkg.sv - opcodes, state and datapath select encodings for the multi-cycle control unit
package mc_control_unit_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_NXT  = 3'd5,
    ST_HALT = 3'd6,
    ST_ERR  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SRC_A_PC   = 2'd0,
    SRC_A_RS1  = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_FOUR = 2'd1,
    SRC_B_IMM  = 2'd2
  } src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_BRANCH = 2'd1,
    ALU_FUNCT  = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_ALU    = 2'd2
  } wb_sel_t;

  // Opcodes that proceed from ID into EX; ECALL is resolved in ID itself.
  function automatic logic goes_to_ex(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI,
      OPC_AUIPC, OPC_BRANCH, OPC_JAL, OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - control unit to datapath/memory signal bundle
interface mc_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             bcond;
  logic             mem_ready;
  logic             ecall_halt;
  logic             pc_write;
  logic             pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic             is_halted;
  logic             fault;
  logic             fault_cause;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  opcode, bcond, mem_ready, ecall_halt,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op, state, is_halted, fault,
           fault_cause, cycle_cnt, instret_cnt
  );

  modport slave (
    output opcode, bcond, mem_ready, ecall_halt,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op, state, is_halted, fault,
           fault_cause, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/mc_control_unit_mem_wait_timer.sv
// rtl/mc_control_unit_mem_wait_timer.sv - consecutive memory-stall counter raising timeout at the limit
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);
  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset, waiting, mem_ready};
      assign timeout = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(MEM_TIMEOUT + 1);
      logic [W-1:0] cnt;
      logic         stall;

      assign stall = waiting & ~mem_ready;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt <= '0;
        end else if (stall) begin
          cnt <= cnt + W'(1);
        end else begin
          cnt <= '0;
        end
      end

      // Fires on the limit-th stalled cycle; a ready in that cycle clears stall and wins.
      assign timeout = stall && (cnt == W'(MEM_TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I core
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_unit_if.master bus
);
  state_t           state_q, state_d;
  logic             halted_q, fault_q, cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             timeout;

  logic    pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
  src_a_t  src_a;
  src_b_t  src_b;
  alu_op_t alu_op;
  wb_sel_t wb_sel;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .waiting   ((state_q == ST_IF) || (state_q == ST_MEM)),
    .mem_ready (bus.mem_ready),
    .timeout   (timeout)
  );

  always_comb begin
    pc_write  = 1'b0;
    pc_source = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    src_a     = SRC_A_PC;
    src_b     = SRC_B_RS2;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALUOUT;
    state_d   = state_q;
    cause_d   = cause_q;
    case (state_q)
      ST_IF: begin
        mem_read = 1'b1;
        ir_write = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = ST_ID;
        end else if (timeout) begin
          state_d = ST_ERR;
          cause_d = 1'b0;
        end
      end
      ST_ID: begin
        src_b = SRC_B_IMM;
        if (bus.opcode == OPC_ECALL) begin
          if (bus.ecall_halt) begin
            state_d = ST_HALT;
          end else begin
            src_b    = SRC_B_FOUR;
            pc_write = 1'b1;
            state_d  = ST_IF;
          end
        end else if (goes_to_ex(bus.opcode)) begin
          state_d = ST_EX;
        end else begin
          state_d = ST_ERR;
          cause_d = 1'b1;
        end
      end
      ST_EX: begin
        case (bus.opcode)
          OPC_OP: begin
            src_a = SRC_A_RS1; alu_op = ALU_FUNCT; state_d = ST_WB;
          end
          OPC_OP_IMM: begin
            src_a = SRC_A_RS1; src_b = SRC_B_IMM; alu_op = ALU_FUNCT; state_d = ST_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            src_a = SRC_A_RS1; src_b = SRC_B_IMM; state_d = ST_MEM;
          end
          OPC_LUI: begin
            src_a = SRC_A_ZERO; src_b = SRC_B_IMM; state_d = ST_WB;
          end
          OPC_AUIPC: begin
            src_b = SRC_B_IMM; state_d = ST_WB;
          end
          OPC_BRANCH: begin
            src_a  = SRC_A_RS1;
            alu_op = ALU_BRANCH;
            if (bus.bcond) begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              state_d   = ST_IF;
            end else begin
              state_d = ST_NXT;
            end
          end
          OPC_JAL: begin
            src_b     = SRC_B_FOUR;
            reg_write = 1'b1;
            wb_sel    = WB_ALU;
            pc_write  = 1'b1;
            pc_source = 1'b1;
            state_d   = ST_IF;
          end
          OPC_JALR: begin
            src_a = SRC_A_RS1; src_b = SRC_B_IMM; state_d = ST_WB;
          end
          default: begin
            state_d = ST_ERR;
            cause_d = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        i_or_d    = 1'b1;
        mem_write = (bus.opcode == OPC_STORE);
        mem_read  = (bus.opcode != OPC_STORE);
        if (bus.mem_ready) begin
          state_d = (bus.opcode == OPC_STORE) ? ST_NXT : ST_WB;
        end else if (timeout) begin
          state_d = ST_ERR;
          cause_d = 1'b0;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        state_d   = ST_NXT;
        if (bus.opcode == OPC_LOAD) begin
          wb_sel = WB_MDR;
        end else if (bus.opcode == OPC_JALR) begin
          src_b     = SRC_B_FOUR;
          wb_sel    = WB_ALU;
          pc_write  = 1'b1;
          pc_source = 1'b1;
          state_d   = ST_IF;
        end
      end
      ST_NXT: begin
        src_b    = SRC_B_FOUR;
        pc_write = 1'b1;
        state_d  = ST_IF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IF;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_HALT) halted_q <= 1'b1;
      if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
        fault_q <= 1'b1;
        cause_q <= cause_d;
      end
      if ((state_q != ST_HALT) && (state_q != ST_ERR)) cycle_q <= cycle_q + CNT_W'(1);
      // A halting ECALL retires on HALT entry since it never writes the PC.
      if (pc_write || ((state_d == ST_HALT) && (state_q != ST_HALT)))
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.pc_write    = pc_write  & ~reset;
  assign bus.mem_read    = mem_read  & ~reset;
  assign bus.mem_write   = mem_write & ~reset;
  assign bus.ir_write    = ir_write  & ~reset;
  assign bus.reg_write   = reg_write & ~reset;
  assign bus.pc_source   = pc_source;
  assign bus.i_or_d      = i_or_d;
  assign bus.wb_sel      = wb_sel;
  assign bus.alu_src_a   = src_a;
  assign bus.alu_src_b   = src_b;
  assign bus.alu_op      = alu_op;
  assign bus.state       = state_q;
  assign bus.is_halted   = halted_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed and randomized instruction sequences against a per-instruction phase model
module tb_mc_control_unit;
  localparam int CNT_W = 32;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011,
                         OP_IMM = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                         ECALL = 7'b1110011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_control_unit_if #(.CNT_W(CNT_W)) bus ();
  mc_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [17:0] exp_q[$];
  bit          rdy_q[$];
  bit          ret_q[$];
  logic [31:0] exp_cyc, exp_ret;
  bit          err_cause;
  logic [6:0]  ops[10];

  // Control word: {state, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op}
  function automatic logic [17:0] mk(int st, int pcw, int pcs, int iord, int mrd, int mwr,
                                     int irw, int rw, int wbs, int asa, int asb, int aop);
    logic [17:0] w;
    w = {st[2:0], pcw[0], pcs[0], iord[0], mrd[0], mwr[0], irw[0], rw[0],
         wbs[1:0], asa[1:0], asb[1:0], aop[1:0]};
    return w;
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [17:0] c, input bit r, input bit rt);
    exp_q.push_back(c);
    rdy_q.push_back(r);
    ret_q.push_back(rt);
  endtask

  // Expected cycle-by-cycle phases of one instruction, from the instruction-class rules.
  task automatic plan_instr(input logic [6:0] op, input bit bc, input int ifw, input int memw);
    logic [17:0] nxt, wb_ar, mem_c;
    bit ld;
    nxt   = mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    wb_ar = mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < ifw; i++) push(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    push(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    if (op == ECALL) begin
      push(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), rnd(), 1'b1);
      return;
    end
    push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), rnd(), 1'b0);
    case (op)
      OP:     begin push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2), rnd(), 0); push(wb_ar, rnd(), 0); push(nxt, rnd(), 1); end
      OP_IMM: begin push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2), rnd(), 0); push(wb_ar, rnd(), 0); push(nxt, rnd(), 1); end
      LUI:    begin push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0), rnd(), 0); push(wb_ar, rnd(), 0); push(nxt, rnd(), 1); end
      AUIPC:  begin push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), rnd(), 0); push(wb_ar, rnd(), 0); push(nxt, rnd(), 1); end
      LOAD, STORE: begin
        ld = (op == LOAD);
        push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), rnd(), 0);
        mem_c = mk(3, 0, 0, 1, ld, !ld, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < memw; i++) push(mem_c, 1'b0, 1'b0);
        push(mem_c, 1'b1, 1'b0);
        if (ld) push(mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), rnd(), 0);
        push(nxt, rnd(), 1);
      end
      BRANCH: begin
        push(mk(2, bc, bc, 0, 0, 0, 0, 0, 0, 1, 0, 1), rnd(), bc);
        if (!bc) push(nxt, rnd(), 1);
      end
      JAL:  push(mk(2, 1, 1, 0, 0, 0, 0, 1, 2, 0, 1, 0), rnd(), 1);
      JALR: begin
        push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), rnd(), 0);
        push(mk(4, 1, 1, 0, 0, 0, 0, 1, 2, 0, 1, 0), rnd(), 1);
      end
      default: ;
    endcase
  endtask

  task automatic execute(input logic [6:0] op, input bit bc, input bit eh);
    while (exp_q.size() > 0) begin
      logic [17:0] c, obs;
      logic [2:0]  sts, exp_sts;
      bit          r, rt;
      c  = exp_q.pop_front();
      r  = rdy_q.pop_front();
      rt = ret_q.pop_front();
      bus.opcode = op; bus.bcond = bc; bus.ecall_halt = eh; bus.mem_ready = r;
      @(negedge clk);
      obs = {bus.state, bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
             bus.ir_write, bus.reg_write, bus.wb_sel, bus.alu_src_a, bus.alu_src_b, bus.alu_op};
      sts = {bus.is_halted, bus.fault, bus.fault_cause};
      exp_sts = {c[17:15] == 3'd6, c[17:15] == 3'd7, (c[17:15] == 3'd7) ? err_cause : 1'b0};
      vectors++;
      assert (obs === c) else begin
        miscompares++;
        $error("FAIL ctl op=%b st=%0d observed=%h expected=%h", op, c[17:15], obs, c);
      end
      vectors++;
      assert (sts === exp_sts) else begin
        miscompares++;
        $error("FAIL status observed=%b expected=%b", sts, exp_sts);
      end
      vectors++;
      assert (bus.cycle_cnt === exp_cyc) else begin
        miscompares++;
        $error("FAIL cycle_cnt observed=%0d expected=%0d", bus.cycle_cnt, exp_cyc);
      end
      vectors++;
      assert (bus.instret_cnt === exp_ret) else begin
        miscompares++;
        $error("FAIL instret_cnt observed=%0d expected=%0d", bus.instret_cnt, exp_ret);
      end
      @(posedge clk); #1;
      if (c[17:15] < 3'd6) exp_cyc++;
      if (rt) exp_ret++;
    end
  endtask

  task automatic chk_cnt(input logic [31:0] cyc, input logic [31:0] ret);
    vectors++;
    assert (bus.cycle_cnt === cyc) else begin
      miscompares++;
      $error("FAIL latency_cycles observed=%0d expected=%0d", bus.cycle_cnt, cyc);
    end
    vectors++;
    assert (bus.instret_cnt === ret) else begin
      miscompares++;
      $error("FAIL retired observed=%0d expected=%0d", bus.instret_cnt, ret);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP; bus.ecall_halt = 1'b0;
    @(negedge clk);
    vectors++;
    assert ({bus.pc_write, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write} === 5'b0) else begin
      miscompares++;
      $error("FAIL reset_enables observed=%b expected=00000",
             {bus.pc_write, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cyc = '0; exp_ret = '0; err_cause = 1'b0;
    vectors++;
    assert ({bus.state, bus.is_halted, bus.fault, bus.fault_cause} === 6'b0) else begin
      miscompares++;
      $error("FAIL reset_state observed=%b expected=000000",
             {bus.state, bus.is_halted, bus.fault, bus.fault_cause});
    end
    chk_cnt(32'd0, 32'd0);
  endtask

  initial begin
    logic [6:0] op;
    bit         bc, eh;
    ops = '{OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR, ECALL};
    bus.opcode = OP; bus.bcond = 1'b0; bus.mem_ready = 1'b1; bus.ecall_halt = 1'b0;
    do_reset();

    plan_instr(OP, 1'b0, 0, 0);     execute(OP, 1'b0, 1'b0);     chk_cnt(32'd5, 32'd1);
    plan_instr(LOAD, 1'b0, 0, 3);   execute(LOAD, 1'b0, 1'b0);   chk_cnt(32'd14, 32'd2);
    plan_instr(BRANCH, 1'b1, 0, 0); execute(BRANCH, 1'b1, 1'b0); chk_cnt(32'd17, 32'd3);
    plan_instr(BRANCH, 1'b0, 0, 0); execute(BRANCH, 1'b0, 1'b0); chk_cnt(32'd21, 32'd4);
    plan_instr(JALR, 1'b0, 0, 0);   execute(JALR, 1'b0, 1'b0);   chk_cnt(32'd25, 32'd5);
    plan_instr(ECALL, 1'b0, 0, 0);  execute(ECALL, 1'b0, 1'b0);  chk_cnt(32'd27, 32'd6);

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 9)];
      bc = rnd();
      eh = (op == ECALL) ? 1'b0 : rnd();
      plan_instr(op, bc, $urandom_range(0, 2), $urandom_range(0, 3));
      execute(op, bc, eh);
    end

    // Halting ECALL: retires, then HALT absorbs with all enables low.
    push(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), 1'b0);
    execute(ECALL, 1'b0, 1'b1);
    do_reset();

    // Fetch timeout after four stalled IF cycles; counter frozen in ERR.
    for (int i = 0; i < 4; i++) push(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), 1'b0);
    err_cause = 1'b0;
    execute(OP, 1'b0, 1'b0);
    chk_cnt(32'd4, 32'd0);
    do_reset();

    // Ready on the fourth cycle beats the limit.
    plan_instr(OP, 1'b0, 3, 0); execute(OP, 1'b0, 1'b0); chk_cnt(32'd8, 32'd1);

    // Store that stalls in MEM until timeout.
    plan_instr(STORE, 1'b0, 0, 0);
    void'(exp_q.pop_back()); void'(rdy_q.pop_back()); void'(ret_q.pop_back());
    void'(exp_q.pop_back()); void'(rdy_q.pop_back()); void'(ret_q.pop_back());
    for (int i = 0; i < 4; i++) push(mk(3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    push(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    err_cause = 1'b0;
    execute(STORE, 1'b0, 1'b0);
    do_reset();

    // Illegal opcode in ID.
    push(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd(), 1'b0);
    err_cause = 1'b1;
    execute(7'b0000000, 1'b0, 1'b0);
    do_reset();

    // Reset mid-instruction, then a clean instruction.
    push(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), 1'b1, 1'b0);
    push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), 1'b1, 1'b0);
    execute(LOAD, 1'b0, 1'b0);
    do_reset();
    plan_instr(JAL, 1'b0, 1, 0); execute(JAL, 1'b0, 1'b0); chk_cnt(32'd4, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
